// File: rtl/io_map_pkg.sv
// IO subsystem address map (addr[7:2] word selects) and default data width.
// Shared by the input sampler and its bench; the output port owns IO_ADDR_OUT0.
package io_map_pkg;

    localparam int IO_DATA_W = 32;

    localparam logic [5:0] IO_ADDR_OUT0 = 6'b100000;
    localparam logic [5:0] IO_ADDR_IN0  = 6'b110000;
    localparam logic [5:0] IO_ADDR_IN1  = 6'b110001;
    localparam logic [5:0] IO_ADDR_CHG0 = 6'b110010;
    localparam logic [5:0] IO_ADDR_CHG1 = 6'b110011;

endpackage

// File: rtl/io_input_sampler_if.sv
// CPU read-side bus of the input sampler: address, read strobe, combinational data, change IRQ.
// Read data is valid in the same cycle as addr; no backpressure.
interface io_input_sampler_if
    import io_map_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W
);
    logic [31:0]       addr;
    logic              read_io_enable;
    logic [DATA_W-1:0] io_read_data;
    logic              in_change;

    modport master (
        output addr,
        output read_io_enable,
        input  io_read_data,
        input  in_change
    );

    modport slave (
        input  addr,
        input  read_io_enable,
        output io_read_data,
        output in_change
    );
endinterface

// File: rtl/io_debounce.sv
// One input word: 2-flop sync + whole-word debounce (IO_INPUT_DEBOUNCE_EN) into stable; no backpressure.
// Latency: DB_CYCLES+2 edges with debounce, 2 edges without; stable_next is the value stable takes next edge.
module io_debounce
    import io_map_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int DB_CYCLES = 16
)
(
    input  logic              io_clk,
    input  logic              clrn,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] stable,
    output logic [DATA_W-1:0] stable_next
);

    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

`ifdef IO_INPUT_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

    logic [DATA_W-1:0] cand;
    logic [DATA_W-1:0] cand_next;
    logic [15:0]       cnt;
    logic [15:0]       cnt_next;

    // Any bit differing from the candidate restarts the whole word's count.
    always_comb begin
        cand_next   = cand;
        cnt_next    = cnt;
        stable_next = stable;
        if (s2 != cand) begin
            cand_next = s2;
            cnt_next  = '0;
        end else if (cand != stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = cand;
                cnt_next    = '0;
            end else begin
                cnt_next = cnt + 16'd1;
            end
        end else begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            cand <= '0;
            cnt  <= '0;
        end else begin
            cand <= cand_next;
            cnt  <= cnt_next;
        end
    end
`else
    logic unused_db_cycles;

    assign stable_next      = s2;
    assign unused_db_cycles = ^DB_CYCLES;
`endif

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            stable <= '0;
        end else begin
            stable <= stable_next;
        end
    end

endmodule

// File: rtl/io_input_sampler.sv
// Memory-mapped input ports: synced/debounced words plus read-to-clear change flags (IO_INPUT_DEBOUNCE_EN).
// Read data combinational, same cycle; flags update at posedge io_clk; no backpressure.
module io_input_sampler
    import io_map_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int DB_CYCLES = 16
)
(
    input  logic              io_clk,
    input  logic              clrn,
    io_input_sampler_if.slave bus,
    input  logic [DATA_W-1:0] in_port0,
    input  logic [DATA_W-1:0] in_port1
);

    logic [DATA_W-1:0] stable0;
    logic [DATA_W-1:0] stable0_next;
    logic [DATA_W-1:0] stable1;
    logic [DATA_W-1:0] stable1_next;
    logic [DATA_W-1:0] chg0;
    logic [DATA_W-1:0] chg1;
    logic [DATA_W-1:0] clr0;
    logic [DATA_W-1:0] clr1;
    logic [DATA_W-1:0] rdata;
    logic [5:0]        reg_sel;
    logic              unused_addr_bits;

    io_debounce #(
        .DATA_W    (DATA_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_db0 (
        .io_clk      (io_clk),
        .clrn        (clrn),
        .din         (in_port0),
        .stable      (stable0),
        .stable_next (stable0_next)
    );

    io_debounce #(
        .DATA_W    (DATA_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_db1 (
        .io_clk      (io_clk),
        .clrn        (clrn),
        .din         (in_port1),
        .stable      (stable1),
        .stable_next (stable1_next)
    );

    assign reg_sel          = bus.addr[7:2];
    assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

    assign clr0 = (bus.read_io_enable && (reg_sel == IO_ADDR_CHG0)) ? '1 : '0;
    assign clr1 = (bus.read_io_enable && (reg_sel == IO_ADDR_CHG1)) ? '1 : '0;

    // A transition landing on the clearing edge survives the clear.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            chg0 <= '0;
            chg1 <= '0;
        end else begin
            chg0 <= (chg0 & ~clr0) | (stable0 ^ stable0_next);
            chg1 <= (chg1 & ~clr1) | (stable1 ^ stable1_next);
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            IO_ADDR_IN0:  rdata = stable0;
            IO_ADDR_IN1:  rdata = stable1;
            IO_ADDR_CHG0: rdata = chg0;
            IO_ADDR_CHG1: rdata = chg1;
            IO_ADDR_OUT0: rdata = '0;   // answered by the output port register
            default:      rdata = '0;
        endcase
    end

    assign bus.io_read_data = rdata;
    assign bus.in_change    = (|chg0) | (|chg1);

endmodule

// File: tb/tb_io_input_sampler.sv
// Directed bench for io_input_sampler; expected latency follows IO_INPUT_DEBOUNCE_EN.
module tb_io_input_sampler;
    import io_map_pkg::*;

    localparam int DB = 16;
`ifdef IO_INPUT_DEBOUNCE_EN
    localparam int LAT = DB + 2;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit DEB = 1'b0;
`endif

    logic        io_clk = 1'b0;
    logic        clrn;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    int          errors = 0;
    int          checks = 0;

    io_input_sampler_if #(.DATA_W(32)) bus ();

    io_input_sampler #(
        .DATA_W    (32),
        .DB_CYCLES (DB)
    ) dut (
        .io_clk   (io_clk),
        .clrn     (clrn),
        .bus      (bus),
        .in_port0 (in_port0),
        .in_port1 (in_port1)
    );

    always #5 io_clk = ~io_clk;

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus.addr = {24'h0, a, 2'b00};
        #1;
        d = bus.io_read_data;
        check(tag, d, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'h0, bus.in_change}, {31'h0, exp});
    endtask

    task automatic rd_strobe(input logic [5:0] a);
        bus.addr           = {24'h0, a, 2'b00};
        bus.read_io_enable = 1'b1;
        tick();
        bus.read_io_enable = 1'b0;
    endtask

    initial begin
        bus.addr           = '0;
        bus.read_io_enable = 1'b0;
        in_port0           = 32'hFFFF_FFFF;
        in_port1           = 32'h0;
        clrn               = 1'b0;
        #2;
        chk_reg("rst_in0", IO_ADDR_IN0, 32'h0);
        chk_irq("rst_irq", 1'b0);
        tick();
        tick();
        chk_reg("rst_chg0", IO_ADDR_CHG0, 32'h0);

        // Release: first edge after this is k.
        clrn = 1'b1;
        repeat (LAT) tick();
        chk_reg("acq_in0_early", IO_ADDR_IN0, 32'h0);
        tick();
        chk_reg("acq_in0", IO_ADDR_IN0, 32'hFFFF_FFFF);
        chk_reg("acq_chg0", IO_ADDR_CHG0, 32'hFFFF_FFFF);
        chk_irq("acq_irq", 1'b1);
        rd_strobe(IO_ADDR_CHG0);
        chk_reg("acq_chg0_clr", IO_ADDR_CHG0, 32'h0);
        chk_irq("acq_irq_clr", 1'b0);

        // Latency on port 1.
        in_port1 = 32'h0000_00A5;
        repeat (LAT) tick();
        chk_reg("lat_in1_early", IO_ADDR_IN1, 32'h0);
        chk_irq("lat_irq_early", 1'b0);
        tick();
        chk_reg("lat_in1", IO_ADDR_IN1, 32'h0000_00A5);
        chk_irq("lat_irq", 1'b1);
        chk_reg("lat_chg1", IO_ADDR_CHG1, 32'h0000_00A5);

        // Decode holes and cross-port independence of the clear.
        chk_reg("dec_out0", IO_ADDR_OUT0, 32'h0);
        chk_reg("dec_3f", 6'b111111, 32'h0);
        rd_strobe(IO_ADDR_CHG0);
        chk_reg("dec_chg1_kept", IO_ADDR_CHG1, 32'h0000_00A5);

        // Bounce on bit 3: nine toggles five cycles apart, settling at 0.
        for (int i = 0; i < 9; i++) begin
            in_port0[3] = ~in_port0[3];
            if (i < 8) repeat (5) tick();
        end
        repeat (LAT) tick();
        chk_reg("bnc_in0_early", IO_ADDR_IN0, 32'hFFFF_FFFF);
        chk_reg("bnc_chg0_mid", IO_ADDR_CHG0, DEB ? 32'h0 : 32'h0000_0008);
        tick();
        chk_reg("bnc_in0", IO_ADDR_IN0, 32'hFFFF_FFF7);
        chk_reg("bnc_chg0", IO_ADDR_CHG0, 32'h0000_0008);

        // Clear read on the same edge that bit 7 falls.
        in_port0 = 32'hFFFF_FF77;
        repeat (LAT) tick();
        chk_reg("col_in0_early", IO_ADDR_IN0, 32'hFFFF_FFF7);
        rd_strobe(IO_ADDR_CHG0);
        chk_reg("col_chg0", IO_ADDR_CHG0, 32'h0000_0080);
        chk_reg("col_chg1", IO_ADDR_CHG1, 32'h0000_00A5);
        chk_reg("col_in0", IO_ADDR_IN0, 32'hFFFF_FF77);

        // Stable reads have no side effects; port clears are independent.
        rd_strobe(IO_ADDR_IN0);
        chk_reg("sr_chg0", IO_ADDR_CHG0, 32'h0000_0080);
        rd_strobe(IO_ADDR_CHG1);
        chk_reg("c1_chg1", IO_ADDR_CHG1, 32'h0);
        chk_reg("c1_chg0", IO_ADDR_CHG0, 32'h0000_0080);
        rd_strobe(IO_ADDR_CHG0);
        chk_irq("c0_irq", 1'b0);

        // Reset in the middle of acquiring a new port-1 value.
        in_port1 = 32'h0000_000F;
        tick();
        tick();
        tick();
        clrn = 1'b0;
        chk_reg("mr_in1", IO_ADDR_IN1, 32'h0);
        chk_irq("mr_irq", 1'b0);
        tick();
        clrn = 1'b1;
        repeat (LAT) tick();
        chk_reg("mr_in1_early", IO_ADDR_IN1, 32'h0);
        chk_reg("mr_in0_early", IO_ADDR_IN0, 32'h0);
        tick();
        chk_reg("mr_in1", IO_ADDR_IN1, 32'h0000_000F);
        chk_reg("mr_in0", IO_ADDR_IN0, 32'hFFFF_FF77);
        chk_reg("mr_chg1", IO_ADDR_CHG1, 32'h0000_000F);
        chk_reg("mr_chg0", IO_ADDR_CHG0, 32'hFFFF_FF77);

        // Single-cycle glitch on bit 3.
        rd_strobe(IO_ADDR_CHG0);
        rd_strobe(IO_ADDR_CHG1);
        in_port0[3] = 1'b1;
        tick();
        in_port0[3] = 1'b0;
        repeat (LAT + 4) tick();
        chk_reg("gl_in0", IO_ADDR_IN0, 32'hFFFF_FF77);
        chk_reg("gl_chg0", IO_ADDR_CHG0, DEB ? 32'h0 : 32'h0000_0008);
        chk_irq("gl_irq", !DEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
